// File: rtl/ps2_line_buffer.sv
// PS/2 Set-2 scancode to ASCII line editor with backspace.
// ENTER commits the line, which is held until cmd_ack.
module ps2_line_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 5
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 key_valid,
   input  logic [7:0]           key_data,
   input  logic                 cmd_ack,
   output logic [8*DEPTH-1:0]   line_data,
   output logic [CNT_W-1:0]     char_count,
   output logic                 line_ready,
   output logic                 overflow
);

   typedef enum logic [1:0] {
      S_IDLE, S_EXT, S_BRK, S_READY
   } state_t;

   typedef enum logic [1:0] {
      K_NONE, K_CHAR, K_BS, K_ENT
   } kind_t;

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   state_t               state, state_n;
   kind_t                kind;
   logic [7:0]           ascii;
   logic [8*DEPTH-1:0]   data_n;
   logic [CNT_W-1:0]     cnt_n;
   logic                 ovf_n;

   always_comb begin
      ascii = 8'h00;
      case (key_data)
         8'h1C: ascii = 8'h41;
         8'h32: ascii = 8'h42;
         8'h21: ascii = 8'h43;
         8'h23: ascii = 8'h44;
         8'h24: ascii = 8'h45;
         8'h2B: ascii = 8'h46;
         8'h34: ascii = 8'h47;
         8'h33: ascii = 8'h48;
         8'h43: ascii = 8'h49;
         8'h3B: ascii = 8'h4A;
         8'h42: ascii = 8'h4B;
         8'h4B: ascii = 8'h4C;
         8'h3A: ascii = 8'h4D;
         8'h31: ascii = 8'h4E;
         8'h44: ascii = 8'h4F;
         8'h4D: ascii = 8'h50;
         8'h15: ascii = 8'h51;
         8'h2D: ascii = 8'h52;
         8'h1B: ascii = 8'h53;
         8'h2C: ascii = 8'h54;
         8'h3C: ascii = 8'h55;
         8'h2A: ascii = 8'h56;
         8'h1D: ascii = 8'h57;
         8'h22: ascii = 8'h58;
         8'h35: ascii = 8'h59;
         8'h1A: ascii = 8'h5A;
         8'h45: ascii = 8'h30;
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20;
         default: ascii = 8'h00;
      endcase
   end

   // every printable code maps to a non-zero ASCII value
   always_comb begin
      kind = K_NONE;
      if (ascii != 8'h00) kind = K_CHAR;
      else if (key_data == 8'h66) kind = K_BS;
      else if (key_data == 8'h5A) kind = K_ENT;
   end

   always_comb begin
      state_n = state;
      data_n  = line_data;
      cnt_n   = char_count;
      ovf_n   = overflow;
      unique case (state)
         S_IDLE: begin
            if (key_valid) begin
               if (key_data == 8'hF0) state_n = S_BRK;
               else if (key_data == 8'hE0) state_n = S_EXT;
               else begin
                  unique case (kind)
                     K_CHAR: begin
                        if (char_count < FULL) begin
                           data_n      = line_data << 8;
                           data_n[7:0] = ascii;
                           cnt_n       = char_count + CNT_W'(1);
                        end else begin
                           ovf_n = 1'b1;
                        end
                     end
                     K_BS: begin
                        if (char_count != '0) begin
                           data_n = line_data >> 8;
                           cnt_n  = char_count - CNT_W'(1);
                        end
                     end
                     K_ENT: begin
                        if (char_count != '0) state_n = S_READY;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_EXT: begin
            if (key_valid)
               state_n = (key_data == 8'hF0) ? S_BRK : S_IDLE;
         end
         S_BRK: begin
            if (key_valid) state_n = S_IDLE;
         end
         S_READY: begin
            if (cmd_ack) begin
               state_n = S_IDLE;
               data_n  = '0;
               cnt_n   = '0;
               ovf_n   = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         line_data  <= '0;
         char_count <= '0;
         overflow   <= 1'b0;
         line_ready <= 1'b0;
      end else begin
         state      <= state_n;
         line_data  <= data_n;
         char_count <= cnt_n;
         overflow   <= ovf_n;
         line_ready <= (state_n == S_READY);
      end
   end

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Bench for ps2_line_buffer: directed test plan plus random
// scancode traffic against a queue-based line model.
module tb_ps2_line_buffer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 5;

   logic               clock = 1'b0;
   logic               resetn = 1'b0;
   logic               key_valid = 1'b0;
   logic [7:0]         key_data = 8'h00;
   logic               cmd_ack = 1'b0;
   logic [8*DEPTH-1:0] line_data;
   logic [CNT_W-1:0]   char_count;
   logic               line_ready;
   logic               overflow;

   int checks = 0;
   int failures = 0;

   ps2_line_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock),
      .resetn(resetn),
      .key_valid(key_valid),
      .key_data(key_data),
      .cmd_ack(cmd_ack),
      .line_data(line_data),
      .char_count(char_count),
      .line_ready(line_ready),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   byte unsigned letters[26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   byte unsigned digits[10] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
      8'h46};

   // model: line as a queue (oldest first), plus prefix bookkeeping
   byte unsigned m_line[$];
   bit           m_ready;
   bit           m_ovf;
   bit           m_skip_next;
   bit           m_ext;

   // 0 = unmapped, 1 = printable, 2 = backspace, 3 = enter
   function automatic int classify(input byte unsigned b,
                                   output byte unsigned a);
      a = 8'h00;
      for (int i = 0; i < 26; i++)
         if (letters[i] == b) begin a = 8'(8'h41 + i); return 1; end
      for (int i = 0; i < 10; i++)
         if (digits[i] == b) begin a = 8'(8'h30 + i); return 1; end
      if (b == 8'h29) begin a = 8'h20; return 1; end
      if (b == 8'h66) return 2;
      if (b == 8'h5A) return 3;
      return 0;
   endfunction

   function automatic logic [8*DEPTH-1:0] model_data();
      logic [8*DEPTH-1:0] d = '0;
      foreach (m_line[i]) d = (d << 8) | (8*DEPTH)'(m_line[i]);
      return d;
   endfunction

   always @(posedge clock or negedge resetn) begin
      byte unsigned a;
      int k;
      if (!resetn) begin
         m_line.delete();
         m_ready = 0; m_ovf = 0; m_skip_next = 0; m_ext = 0;
      end else if (m_ready) begin
         if (cmd_ack) begin
            m_line.delete();
            m_ready = 0; m_ovf = 0;
         end
      end else if (key_valid) begin
         if (m_skip_next) m_skip_next = 0;
         else if (key_data == 8'hF0) begin m_skip_next = 1; m_ext = 0; end
         else if (m_ext) m_ext = 0;
         else if (key_data == 8'hE0) m_ext = 1;
         else begin
            k = classify(key_data, a);
            if (k == 1) begin
               if (m_line.size() < DEPTH) m_line.push_back(a);
               else m_ovf = 1;
            end else if (k == 2) begin
               if (m_line.size() > 0) void'(m_line.pop_back());
            end else if (k == 3) begin
               if (m_line.size() > 0) m_ready = 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (resetn) begin
         chk("model_line_data", 64'(line_data), 64'(model_data()));
         chk("model_char_count", 64'(char_count),
             64'(m_line.size()));
         chk("model_line_ready", 64'(line_ready), 64'(m_ready));
         chk("model_overflow", 64'(overflow), 64'(m_ovf));
      end
   end

   task automatic send(input byte unsigned b);
      key_valid = 1'b1;
      key_data  = b;
      @(posedge clock);
      #1 key_valid = 1'b0;
   endtask

   task automatic tap(input byte unsigned b);
      send(b); send(8'hF0); send(b);
   endtask

   task automatic ack();
      cmd_ack = 1'b1;
      @(posedge clock);
      #1 cmd_ack = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   initial begin
      byte unsigned pool[9];
      do_reset();
      chk("reset_line_data", 64'(line_data), 64'h0);
      chk("reset_count", 64'(char_count), 64'h0);
      chk("reset_ready", 64'(line_ready), 64'h0);
      chk("reset_overflow", 64'(overflow), 64'h0);

      tap(8'h1C); tap(8'h32);
      chk("ab_data", 64'(line_data[15:0]), 64'h4142);
      chk("ab_count", 64'(char_count), 64'd2);
      chk("ab_ovf", 64'(overflow), 64'h0);
      chk("ab_ready", 64'(line_ready), 64'h0);

      do_reset();
      tap(8'h1C); tap(8'h32); tap(8'h21); tap(8'h23); tap(8'h24);
      chk("full_data", 64'(line_data), 64'h41424344);
      chk("full_count", 64'(char_count), 64'd4);
      chk("full_ovf", 64'(overflow), 64'h1);
      send(8'h5A);
      chk("full_ready", 64'(line_ready), 64'h1);
      ack();
      chk("ack_clears_ovf", 64'(overflow), 64'h0);

      do_reset();
      tap(8'h1C); tap(8'h32); tap(8'h66);
      chk("bs_data", 64'(line_data), 64'h00000041);
      chk("bs_count", 64'(char_count), 64'd1);
      repeat (3) tap(8'h66);
      chk("bs_floor_count", 64'(char_count), 64'd0);
      chk("bs_floor_data", 64'(line_data), 64'h0);

      do_reset();
      tap(8'h1C); tap(8'h16);
      send(8'h5A);
      chk("enter_ready", 64'(line_ready), 64'h1);
      send(8'h24);
      chk("ready_frozen", 64'(line_data[15:0]), 64'h4131);
      chk("ready_count", 64'(char_count), 64'd2);
      ack();
      chk("ack_ready", 64'(line_ready), 64'h0);
      chk("ack_count", 64'(char_count), 64'd0);
      chk("ack_data", 64'(line_data), 64'h0);

      do_reset();
      send(8'hE0); send(8'h1C);
      send(8'hE0); send(8'hF0); send(8'h1C);
      send(8'h5A);
      chk("ext_count", 64'(char_count), 64'd0);
      chk("ext_ready", 64'(line_ready), 64'h0);

      send(8'h1C); send(8'hF0);
      #3 resetn = 1'b0;
      #1;
      chk("async_data", 64'(line_data), 64'h0);
      chk("async_count", 64'(char_count), 64'd0);
      @(posedge clock);
      #1 resetn = 1'b1;
      send(8'h1C);
      chk("post_reset_data", 64'(line_data), 64'h41);
      chk("post_reset_count", 64'(char_count), 64'd1);

      pool = '{8'h1C, 8'h45, 8'h29, 8'h3A, 8'hF0, 8'hE0, 8'h66,
               8'h5A, 8'h00};
      for (int i = 0; i < 3000; i++) begin
         int p;
         p = $urandom_range(0, 8);
         key_valid = ($urandom_range(0, 9) < 7);
         key_data  = (p == 8) ? 8'($urandom) :
                     (p == 0) ? letters[$urandom_range(0, 25)] :
                     (p == 1) ? digits[$urandom_range(0, 9)] : pool[p];
         cmd_ack   = ($urandom_range(0, 9) < 2);
         @(posedge clock);
         #1;
      end
      key_valid = 1'b0;
      cmd_ack   = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
